// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March-style RAM self-test engine.
// State/phase encodings, default background pattern and cycle budget.
package ram_bist_pkg;

    localparam int          ADDR_W_DEF   = 5;
    localparam int          DATA_W_DEF   = 32;
    localparam int          DEPTH        = 32;
    localparam int          CLEAN_CYCLES = 288;
    localparam logic [31:0] PATTERN_DEF  = 32'h5555AAAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_RA,
        S_RC,
        S_WR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        P_W0,
        P_R0W1,
        P_R1W0,
        P_R0
    } phase_e;

endpackage

// File: rtl/ram_bist_if.sv
// Single-port RAM bus as seen by the self-test initiator.
// The master drives the request side and samples dout.
interface ram_bist_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              ena;
    logic              wena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output ena, wena, addr, din, input dout);
    modport slave  (input ena, wena, addr, din, output dout);
endinterface

// File: rtl/ram_bist_addr_cnt.sv
// Address counter for the march sequence: up/down with clear and load-to-max.
// last flags the final address of the current sweep direction.
module ram_bist_addr_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         set_max,
    input  logic         up,
    input  logic         dn,
    input  logic         down_dir,
    output logic [W-1:0] cnt,
    output logic         last
);
    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)          cnt_d = '0;
        else if (set_max) cnt_d = '1;
        else if (up)      cnt_d = cnt_q + W'(1);
        else if (dn)      cnt_d = cnt_q - W'(1);
    end

    assign cnt  = cnt_q;
    assign last = down_dir ? (cnt_q == '0) : (cnt_q == '1);
endmodule

// File: rtl/ram_bist.sv
// March-style BIST initiator: W0, R0W1 up, R1W0 down, R0 up.
// Stops at the first mismatch and reports its address and read data.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(PATTERN_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    ram_bist_if.master        ram
);
    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_data_q, err_data_d;

    logic              clr, set_max, up, dn;
    logic              down_dir, last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_data;

    assign down_dir = (phase_q == P_R1W0);
    assign exp_data = down_dir ? ~PATTERN : PATTERN;

    ram_bist_addr_cnt #(.W(ADDR_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .set_max  (set_max),
        .up       (up),
        .dn       (dn),
        .down_dir (down_dir),
        .cnt      (addr),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= P_W0;
            pass_q     <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pass_q     <= pass_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pass_d     = pass_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        clr        = 1'b0;
        set_max    = 1'b0;
        up         = 1'b0;
        dn         = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_W0;
                    phase_d    = P_W0;
                    pass_d     = 1'b0;
                    err_addr_d = '0;
                    err_data_d = '0;
                    clr        = 1'b1;
                end
            end
            S_W0: begin
                if (last) begin
                    state_d = S_RA;
                    phase_d = P_R0W1;
                    clr     = 1'b1;
                end else begin
                    up = 1'b1;
                end
            end
            S_RA: state_d = S_RC;
            S_RC: begin
                // Mismatch aborts before the write, leaving the faulty cell intact
                if (ram.dout != exp_data) begin
                    err_addr_d = addr;
                    err_data_d = ram.dout;
                    pass_d     = 1'b0;
                    state_d    = S_DONE;
                end else if (phase_q == P_R0) begin
                    if (last) begin
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        up      = 1'b1;
                        state_d = S_RA;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                state_d = S_RA;
                if (last) begin
                    if (phase_q == P_R0W1) begin
                        phase_d = P_R1W0;
                        set_max = 1'b1;
                    end else begin
                        phase_d = P_R0;
                        clr     = 1'b1;
                    end
                end else if (down_dir) begin
                    dn = 1'b1;
                end else begin
                    up = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram.ena  = 1'b0;
        ram.wena = 1'b0;
        ram.din  = '0;
        unique case (state_q)
            S_W0: begin
                ram.ena  = 1'b1;
                ram.wena = 1'b1;
                ram.din  = PATTERN;
            end
            S_RA, S_RC: ram.ena = 1'b1;
            S_WR: begin
                ram.ena  = 1'b1;
                ram.wena = 1'b1;
                ram.din  = (phase_q == P_R0W1) ? ~PATTERN : PATTERN;
            end
            default: ;
        endcase
    end

    assign ram.addr = addr;
    assign busy     = ram.ena;
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign err_addr = err_addr_q;
    assign err_data = err_data_q;
endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a faultable 32x32 RAM model.
// Covers clean runs, injected faults, ignored start, mid-run reset, restart.
module tb_ram_bist;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass;
    logic [4:0]  err_addr;
    logic [31:0] err_data;

    int          checks = 0;
    int          errors = 0;
    int          fault  = 0;
    logic        comb_rd = 1'b0;

    logic [31:0] mem [32];
    logic [31:0] dout_q;

    localparam logic [31:0] PAT  = 32'h5555AAAA;
    localparam logic [31:0] NPAT = 32'hAAAA5555;

    ram_bist_if #(.ADDR_W(5), .DATA_W(32)) rif ();

    ram_bist dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_addr (err_addr),
        .err_data (err_data),
        .ram      (rif.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wr_val(logic [4:0] a, logic [31:0] d);
        if (fault == 1 && a == 5'd4)  return d & 32'h7FFFFFFF;
        if (fault == 2 && a == 5'd31) return 32'h0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (rif.ena && rif.wena) mem[rif.addr] <= wr_val(rif.addr, rif.din);
        if (rif.ena) dout_q <= mem[rif.addr];
    end

    assign rif.dout = comb_rd ? mem[rif.addr] : dout_q;

    task automatic run(input int ign_at, output int cyc, output int bsy);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!done && cyc < 400) begin
            if (busy) bsy++;
            start = (cyc == ign_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, pass, rif.ena, rif.wena} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {busy, done, pass, rif.ena, rif.wena});
        end
        checks++;
        if ({err_addr, err_data, rif.addr, rif.din} !== 74'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want 0",
                     err_addr, err_data, rif.addr, rif.din);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean();
        int cyc, bsy;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!done && cyc < 400) begin
            if (busy) bsy++;
            if (cyc == 0) begin
                checks++;
                if ({rif.ena, rif.wena, rif.addr, rif.din} !== {2'b11, 5'd0, PAT}) begin
                    errors++;
                    $display("FAIL w0_first got %b%b %h %h want 11 00 %h",
                             rif.ena, rif.wena, rif.addr, rif.din, PAT);
                end
            end
            if (cyc == 32) begin
                checks++;
                if ({rif.ena, rif.wena, rif.addr} !== {2'b10, 5'd0}) begin
                    errors++;
                    $display("FAIL ra_first got %b%b %h want 10 00",
                             rif.ena, rif.wena, rif.addr);
                end
            end
            if (cyc == 34) begin
                checks++;
                if ({rif.wena, rif.addr, rif.din} !== {1'b1, 5'd0, NPAT}) begin
                    errors++;
                    $display("FAIL wr_first got %b %h %h want 1 00 %h",
                             rif.wena, rif.addr, rif.din, NPAT);
                end
            end
            if (cyc == 128) begin
                checks++;
                if ({rif.wena, rif.addr} !== {1'b0, 5'd31}) begin
                    errors++;
                    $display("FAIL r1w0_first got %b %h want 0 1f",
                             rif.wena, rif.addr);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 288 || bsy !== 288) begin
            errors++;
            $display("FAIL clean_len got %0d/%0d want 288/288", cyc, bsy);
        end
        checks++;
        if ({pass, err_addr, err_data} !== {1'b1, 37'h0}) begin
            errors++;
            $display("FAIL clean_res got %b %h %h want 1 0 0",
                     pass, err_addr, err_data);
        end
        @(negedge clk);
        checks++;
        if ({rif.ena, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL clean_idle got %b want 001", {rif.ena, busy, done});
        end
    endtask

    task automatic test_comb_read();
        int cyc, bsy;
        comb_rd = 1'b1;
        run(-1, cyc, bsy);
        checks++;
        if (cyc !== 288 || pass !== 1'b1) begin
            errors++;
            $display("FAIL comb_read got %0d %b want 288 1", cyc, pass);
        end
        comb_rd = 1'b0;
    endtask

    task automatic test_stuck_bit();
        int cyc, bsy;
        fault = 1;
        run(-1, cyc, bsy);
        checks++;
        if (cyc !== 211 || done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck_end got %0d %b %b want 211 1 0", cyc, done, pass);
        end
        checks++;
        if (err_addr !== 5'd4 || err_data !== 32'h2AAA5555) begin
            errors++;
            $display("FAIL stuck_err got %h %h want 04 2aaa5555", err_addr, err_data);
        end
        fault = 0;
    endtask

    task automatic test_addr31_zero();
        int cyc, bsy;
        fault = 2;
        run(-1, cyc, bsy);
        checks++;
        if (cyc !== 127 || pass !== 1'b0) begin
            errors++;
            $display("FAIL a31_end got %0d %b want 127 0", cyc, pass);
        end
        checks++;
        if (err_addr !== 5'd31 || err_data !== 32'h0) begin
            errors++;
            $display("FAIL a31_err got %h %h want 1f 00000000", err_addr, err_data);
        end
        fault = 0;
    endtask

    task automatic test_restart_after_fail();
        int cyc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({done, pass, err_addr, err_data} !== 39'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clr got %b%b %h %h busy %b want 00 0 0 busy 1",
                     done, pass, err_addr, err_data, busy);
        end
        cyc = 5;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 288 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_end got %0d %b want 288 1", cyc, pass);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, bsy;
        run(50, cyc, bsy);
        checks++;
        if (cyc !== 288 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_ign got %0d %b want 288 1", cyc, pass);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bsy;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, rif.ena, rif.wena, done, pass} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst got %b want 00000",
                     {busy, rif.ena, rif.wena, done, pass});
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_rst_idle got %b want 00", {busy, done});
        end
        run(-1, cyc, bsy);
        checks++;
        if (cyc !== 288 || bsy !== 288 || pass !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got %0d %0d %b want 288 288 1", cyc, bsy, pass);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_clean();
        test_start_ignored();
        test_stuck_bit();
        test_restart_after_fail();
        test_addr31_zero();
        test_comb_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
